// File: rtl/adc_frame_assembler_if.sv
// Bundle between the ADC driver, the frame assembler and the DSP consumer:
// sample strobe inputs, FIFO head outputs and status.
interface adc_frame_assembler_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  logic                       s_valid;
  logic                       s_first;
  logic [DATA_W-1:0]          s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [NUM_CH*DATA_W-1:0]   m_data;
  logic [7:0]                 m_seq;
  logic [$clog2(DEPTH):0]     level;
  logic                       frame_err;
  logic [15:0]                overflow_cnt;

  modport master (
    output s_valid, s_first, s_data, m_ready,
    input  m_valid, m_data, m_seq, level, frame_err, overflow_cnt
  );

  modport slave (
    input  s_valid, s_first, s_data, m_ready,
    output m_valid, m_data, m_seq, level, frame_err, overflow_cnt
  );
endinterface

// File: rtl/adc_frame_assembler.sv
// Groups per-channel ADC sample words into sequence-tagged frames and buffers
// them in a first-word-fall-through FIFO with short-frame and overflow reporting.
module adc_frame_assembler #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_frame_assembler_if.slave bus
);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W   = $clog2(DEPTH) + 1;
  localparam int ADDR_W  = PTR_W - 1;
  localparam int FRAME_W = NUM_CH * DATA_W;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0]  asm_q [NUM_CH];
  logic               slot_we;
  logic [IDX_W-1:0]   slot_sel;
  logic               commit;
  logic               err_nxt;
  logic               frame_err_q;
  logic [FRAME_W-1:0] frame_flat;
  logic [7:0]         seq_q;
  logic [15:0]        ovf_q;

  logic [FRAME_W-1:0] mem_data [DEPTH];
  logic [7:0]         mem_seq  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, level_w;
  logic               full, empty, pop, push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      frame_err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    slot_we   = 1'b0;
    slot_sel  = '0;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_valid) begin
          if (bus.s_first) begin
            slot_we   = 1'b1;
            idx_nxt   = IDX_W'(1);
            state_nxt = COLLECT;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.s_valid) begin
          if (bus.s_first) begin
            // A new conversion started before this one finished: restart.
            err_nxt = 1'b1;
            slot_we = 1'b1;
            idx_nxt = IDX_W'(1);
          end else if (idx == IDX_W'(NUM_CH - 1)) begin
            commit    = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            slot_we  = 1'b1;
            slot_sel = idx;
            idx_nxt  = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (slot_we) asm_q[slot_sel] <= bus.s_data;
  end

  // The last word bypasses the assembly register so the commit is same-edge.
  always_comb begin
    frame_flat = '0;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      frame_flat[k*DATA_W +: DATA_W] = asm_q[k];
    end
    frame_flat[(NUM_CH-1)*DATA_W +: DATA_W] = bus.s_data;
  end

  assign level_w = wr_ptr - rd_ptr;
  assign full    = (level_w == PTR_W'(DEPTH));
  assign empty   = (level_w == '0);
  assign pop     = !empty && bus.m_ready;
  assign push    = commit && (!full || pop);
  assign drop    = commit && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      seq_q  <= '0;
      ovf_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (commit) seq_q <= seq_q + 8'd1;
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_seq[i]  <= '0;
      end
    end else if (push) begin
      mem_data[wr_ptr[ADDR_W-1:0]] <= frame_flat;
      mem_seq[wr_ptr[ADDR_W-1:0]]  <= seq_q;
    end
  end

  assign bus.m_valid      = !empty;
  assign bus.m_data       = mem_data[rd_ptr[ADDR_W-1:0]];
  assign bus.m_seq        = mem_seq[rd_ptr[ADDR_W-1:0]];
  assign bus.level        = level_w;
  assign bus.frame_err    = frame_err_q;
  assign bus.overflow_cnt = ovf_q;
endmodule

// File: tb/tb_adc_frame_assembler.sv
// Randomized scoreboard bench for adc_frame_assembler: a list-based frame
// model predicts stored frames, drops, error pulses and FIFO occupancy.
module tb_adc_frame_assembler;
  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int FRAME_W = NUM_CH * DATA_W;

  typedef struct {
    logic [FRAME_W-1:0] data;
    logic [7:0]         seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_frame_assembler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  adc_frame_assembler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t              sb [$];
  logic [DATA_W-1:0] partial [$];
  bit                in_frame    = 0;
  int                model_level = 0;
  int                model_seq   = 0;
  int                model_ovf   = 0;
  int                model_err   = 0;
  int                obs_err     = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Frame-level model: a conversion is a list of words started by s_first.
  task automatic modelStep(input bit v, input bit f, input logic [DATA_W-1:0] d, input bit rdy);
    bit                 pop_now;
    bit                 do_commit;
    logic [FRAME_W-1:0] fr;
    pop_now   = (model_level > 0) && rdy;
    do_commit = 0;
    fr        = '0;
    if (v) begin
      if (f) begin
        if (in_frame) model_err++;
        partial.delete();
        partial.push_back(d);
        in_frame = 1;
      end else if (!in_frame) begin
        model_err++;
      end else begin
        partial.push_back(d);
      end
      if (in_frame && partial.size() == NUM_CH) begin
        for (int k = 0; k < NUM_CH; k++) fr[k*DATA_W +: DATA_W] = partial[k];
        do_commit = 1;
        in_frame  = 0;
        partial.delete();
      end
    end
    if (do_commit) begin
      if (model_level < DEPTH || pop_now) begin
        sb.push_back('{fr, 8'(model_seq)});
        model_level++;
      end else if (model_ovf < 65535) begin
        model_ovf++;
      end
      model_seq = (model_seq + 1) % 256;
    end
    if (pop_now) model_level--;
  endtask

  task automatic applyStimulus(input bit v, input bit f, input logic [DATA_W-1:0] d, input bit rdy);
    @(posedge clk);
    #1;
    bus.s_valid = v;
    bus.s_first = f;
    bus.s_data  = d;
    bus.m_ready = rdy;
    modelStep(v, f, d, rdy);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    partial.delete();
    sb.delete();
    in_frame    = 0;
    model_level = 0;
    model_seq   = 0;
    model_ovf   = 0;
    @(negedge clk);
    checkOutput("reset_m_valid", bus.m_valid, 0);
    checkOutput("reset_level", bus.level, 0);
    checkOutput("reset_frame_err", bus.frame_err, 0);
    checkOutput("reset_overflow_cnt", bus.overflow_cnt, 0);
    checkOutput("reset_m_seq", bus.m_seq, 0);
    checkOutput("reset_m_data_zero", (bus.m_data == '0), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic sendFrame(input int n, input logic [DATA_W-1:0] first_word, input bit rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, i == 0, (i == 0) ? first_word : DATA_W'($urandom), rdy);
    end
  endtask

  task automatic checkpoint(input string tag);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_level"}, bus.level, model_level);
    checkOutput({tag, "_m_valid"}, bus.m_valid, (model_level != 0));
    checkOutput({tag, "_overflow_cnt"}, bus.overflow_cnt, model_ovf);
    checkOutput({tag, "_frame_err_count"}, obs_err, model_err);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * DEPTH && model_level > 0; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
    end
    checkpoint(tag);
    checkOutput({tag, "_scoreboard_empty"}, sb.size(), 0);
  endtask

  // Monitor: every accepted head frame must match the oldest expected frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.frame_err) obs_err++;
      if (bus.m_valid && bus.m_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_pop: got seq %0d, expected no frame", bus.m_seq);
        end else begin
          e = sb.pop_front();
          if (bus.m_data !== e.data || bus.m_seq !== e.seq) begin
            tests_failed++;
            $display("[TB] FAIL frame: got seq %0d data %h, expected seq %0d data %h",
                     bus.m_seq, bus.m_data, e.seq, e.data);
          end
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    doReset();

    // Nominal frame with counting data, checked right after the last edge.
    for (int i = 0; i < NUM_CH; i++) applyStimulus(1'b1, i == 0, DATA_W'(i), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("nominal_m_valid", bus.m_valid, 1);
    checkOutput("nominal_m_seq", bus.m_seq, 0);
    checkOutput("nominal_slot7", bus.m_data[7*DATA_W +: DATA_W], 7);
    checkOutput("nominal_level", bus.level, 1);
    drain("nominal");

    doReset();
    sendFrame(5, 16'h1234, 1'b0);
    sendFrame(NUM_CH, 16'hA000, 1'b0);
    checkpoint("short");
    checkOutput("short_slot0", bus.m_data[DATA_W-1:0], 16'hA000);
    checkOutput("short_seq", bus.m_seq, 0);
    drain("short_drain");

    doReset();
    applyStimulus(1'b1, 1'b0, 16'h5555, 1'b0);
    checkpoint("stray");
    sendFrame(NUM_CH, 16'h0101, 1'b0);
    checkpoint("after_stray");
    drain("stray_drain");

    doReset();
    for (int n = 0; n < DEPTH + 2; n++) sendFrame(NUM_CH, DATA_W'($urandom), 1'b0);
    checkpoint("overflow");
    checkOutput("overflow_cnt_is_2", bus.overflow_cnt, 2);
    // Full FIFO: the commit edge coincides with a pop.
    for (int i = 0; i < NUM_CH; i++)
      applyStimulus(1'b1, i == 0, DATA_W'($urandom), i == NUM_CH - 1);
    checkpoint("push_pop");
    checkOutput("push_pop_level_full", bus.level, DEPTH);
    drain("overflow_drain");

    doReset();
    sendFrame(3, 16'h0BAD, 1'b0);
    doReset();
    sendFrame(NUM_CH, 16'h0C00, 1'b0);
    checkpoint("mid_reset");
    checkOutput("mid_reset_seq", bus.m_seq, 0);
    drain("mid_reset_drain");

    for (int c = 0; c < 600; c++) begin
      bit v, f;
      v = ($urandom_range(0, 3) != 0);
      f = in_frame ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(v, f, DATA_W'($urandom), $urandom_range(0, 3) == 0);
    end
    checkpoint("random");
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/adc_frame_assembler.md
# adc_frame_assembler

Sits directly downstream of the ADS8528 parallel driver. Groups the per-channel 16-bit sample words from one conversion cycle into a single multi-channel frame and tags each frame with a sequence number. Buffers completed frames in a small first-word-fall-through FIFO for the localization/DSP stage. Reports short frames and FIFO overflow, so downstream timing-difference logic never consumes a frame mixed from two conversions.

## Interface

- NUM_CH, default 8: sample words per conversion frame (2..16).
- DATA_W, default 16: bits per sample word.
- DEPTH, default 16: FIFO capacity in frames; power of two, ≥ 2.
- clk  input  1  system clock; the same clock as the ADC driver.
- rst  input  1  reset; asynchronous and active-high.
- s_valid  input  1  one-cycle strobe; the driver has latched a sample word.
- s_first  input  1  qualifies s_valid; the word is channel 0 of a new conversion.
- s_data  input  DATA_W  sample word, two's complement as delivered by the ADC.
- m_valid  output  1  FIFO head holds a frame.
- m_ready  input  1  consumer accepts the head frame when m_valid && m_ready.
- m_data  output  NUM_CH*DATA_W  head frame; channel k occupies bits [k*DATA_W +: DATA_W].
- m_seq  output  8  sequence number of the head frame.
- level  output  $clog2(DEPTH)+1  frames currently stored.
- frame_err  output  1  one-cycle pulse; a partial frame was discarded, or a stray word arrived.
- overflow_cnt  output  16  count of frames dropped because the FIFO was full; saturates at 16'hFFFF.

## Operation

- Assembler FSM has two states, IDLE and COLLECT. It keeps a channel index idx (0..NUM_CH-1) and an assembly register of NUM_CH words.
- IDLE:
  - s_valid && s_first: store the word at slot 0, set idx=1, go to COLLECT. When NUM_CH==1, commit immediately instead.
  - s_valid && !s_first: drop the word, pulse frame_err, stay in IDLE.
- COLLECT:
  - s_valid && !s_first: store the word at slot idx, then idx+1.
  - When the stored word is slot NUM_CH-1: commit the frame (assembly register plus this word) and return to IDLE.
  - s_valid && s_first: discard the partial frame and pulse frame_err. Restart with this word as slot 0 (idx=1) and stay in COLLECT.
- Sequence counter:
  - 8-bit counter, incremented on every commit attempt whether the frame is stored or dropped. It wraps 255→0.
  - Committed frames carry the pre-increment value.
  - Dropped frames therefore show as gaps in m_seq.
- Commit:
  - FIFO full and no pop in the same cycle: the frame is dropped and overflow_cnt increments (saturating).
  - FIFO full with a simultaneous pop: the frame is stored and level is unchanged.
- FIFO:
  - Circular buffer with write and read pointers of $clog2(DEPTH)+1 bits; the pointers wrap naturally.
  - m_data and m_seq are driven from the entry at the read pointer.
  - Pop happens when m_valid && m_ready.
  - Push and pop in the same cycle leave level unchanged.
- Reset:
  - Asynchronous.
  - Clears the FSM to IDLE, idx, both pointers, the sequence counter and overflow_cnt.
  - A partial frame is discarded silently; frame_err is not pulsed.
  - Stored frames are lost.

## Timing

- Reset values: m_valid=0, level=0, frame_err=0, overflow_cnt=0, m_seq=0. m_data equals the reset contents of entry 0, which are all zeros.
- s_valid is sampled on the rising edge of clk. Back-to-back strobes (one word per cycle) are supported with no stall. There is no back-pressure toward the driver.
- Latency: when the last word is sampled at edge t, m_valid is high after edge t if the FIFO was empty. The frame is visible on m_data in the same cycle.
- frame_err is a registered pulse, high for the single cycle after the offending edge.
- A stray word and a restart never occur on the same edge, so each offending edge yields exactly one frame_err pulse.
- Full FIFO (level==DEPTH): m_valid=1. Empty FIFO: m_valid=0; m_data and m_seq hold don't-care values.
- m_ready is ignored while m_valid=0. An underflow pop is impossible.
- s_first is ignored when s_valid=0.

## Test plan

- Nominal frame:
  - Stimulus: after reset, NUM_CH=8; s_first with 16'h0000, then 16'h0001..16'h0007 on consecutive cycles.
  - Required: m_valid rises after the 8th edge, m_data slots equal 0..7, m_seq=0, level=1.
- Short frame:
  - Stimulus: 5 words, then s_first with 16'hA000, then 7 more words.
  - Required: one frame_err pulse; only one frame is stored, with slot 0 = 16'hA000 and m_seq=0.
- Stray word:
  - Stimulus: s_valid with s_first=0 in IDLE.
  - Required: frame_err pulse, level stays 0, the FSM stays in IDLE.
- Overflow:
  - Stimulus: m_ready=0, DEPTH=16; push 18 frames.
  - Required: level=16, overflow_cnt=2. After draining, m_seq reads 0..15; the next frame gets seq 18.
- Simultaneous push/pop:
  - Stimulus: with the FIFO full, commit a frame on the same edge as a pop.
  - Required: level stays 16, overflow_cnt unchanged, the new frame appears last.
- Reset mid-frame:
  - Stimulus: assert rst after 3 words, then send a complete frame.
  - Required: no frame_err; the only stored frame has m_seq=0 and overflow_cnt=0.
